// File: rtl/ex_fp_pkg.sv
// ex_fp_pkg: shared constants and types for the EX-stage FP scheduler
package ex_fp_pkg;
    localparam logic [3:0] ALU_FP_ADD = 4'd9;
    localparam logic [3:0] ALU_FP_MUL = 4'd10;
    localparam int LAT_W = 4;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    function automatic logic is_fp(input logic [3:0] c);
        return c == ALU_FP_ADD || c == ALU_FP_MUL;
    endfunction
endpackage

// File: rtl/ex_fp_sched_if.sv
// ex_fp_sched_if: ID/EX issue and EX/MEM result handshakes of the FP scheduler
interface ex_fp_sched_if;
    logic        issue_valid;
    logic        issue_ready;
    logic [3:0]  issue_ctrl;
    logic [4:0]  issue_rd;
    logic [31:0] issue_a;
    logic [31:0] issue_b;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [4:0]  res_rd;
    modport master (
        output issue_valid, issue_ctrl, issue_rd, issue_a, issue_b, res_ready,
        input  issue_ready, res_valid, res_data, res_rd
    );
    modport slave (
        input  issue_valid, issue_ctrl, issue_rd, issue_a, issue_b, res_ready,
        output issue_ready, res_valid, res_data, res_rd
    );
endinterface

// File: rtl/ex_fp_sched.sv
// ex_fp_sched: issue/sequencing controller for the multi-cycle FP add/mul units
module ex_fp_sched
    import ex_fp_pkg::*;
#(
    parameter int ADD_LAT = 3,
    parameter int MUL_LAT = 4
) (
    input  logic         clk,
    input  logic         rst,
    ex_fp_sched_if.slave bus,
    input  logic         flush,
    output logic [31:0]  fp_a,
    output logic [31:0]  fp_b,
    input  logic [31:0]  fp_add_ans,
    input  logic [31:0]  fp_mul_ans,
    output logic         stall_dx,
    output logic         busy,
    output logic         illegal,
    output logic [15:0]  ops_done
);
    state_t state, state_nx;
    logic [LAT_W-1:0] count;
    logic sel;
    logic [4:0] rd;
    logic fp_op, accept, consume, last;

    always_comb begin
        fp_op = is_fp(bus.issue_ctrl);
        accept = bus.issue_valid && bus.issue_ready && fp_op;
        consume = state == DONE && bus.res_ready && !flush;
        last = state == BUSY && count == '0;
    end

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nx;

    always_comb
        state_nx = flush   ? IDLE :
                   accept  ? BUSY :
                   last    ? DONE :
                   consume ? IDLE : state;

    always_comb begin
        bus.issue_ready = !flush && (state == IDLE || (state == DONE && bus.res_ready));
        bus.res_valid = state == DONE;
        busy = state != IDLE;
        stall_dx = bus.issue_valid && !bus.issue_ready && fp_op;
    end

    // Operands are only written on acceptance so the units see them stable for the whole latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            fp_a <= '0;
            fp_b <= '0;
            sel <= 1'b0;
            rd <= '0;
            count <= '0;
            bus.res_data <= '0;
            bus.res_rd <= '0;
            ops_done <= '0;
            illegal <= 1'b0;
        end else begin
            illegal <= bus.issue_valid && bus.issue_ready && !fp_op;
            if (flush)
                count <= '0;
            else if (accept) begin
                fp_a <= bus.issue_a;
                fp_b <= bus.issue_b;
                sel <= bus.issue_ctrl == ALU_FP_MUL;
                rd <= bus.issue_rd;
                count <= bus.issue_ctrl == ALU_FP_MUL ? LAT_W'(MUL_LAT - 1) : LAT_W'(ADD_LAT - 1);
            end else if (state == BUSY && count != '0)
                count <= count - 1'b1;
            if (last && !flush) begin
                bus.res_data <= sel ? fp_mul_ans : fp_add_ans;
                bus.res_rd <= rd;
            end
            if (consume)
                ops_done <= ops_done + 1'b1;
        end
    end
endmodule

// File: tb/tb_ex_fp_sched.sv
// tb_ex_fp_sched: directed self-checking bench for ex_fp_sched
module tb_ex_fp_sched;
    logic clk = 0;
    logic rst = 0;
    logic flush = 0;
    logic [31:0] fp_a, fp_b;
    logic [31:0] fp_add_ans = 0, fp_mul_ans = 0;
    logic stall_dx, busy, illegal;
    logic [15:0] ops_done;
    int errors = 0;
    int checks = 0;

    ex_fp_sched_if bus();

    ex_fp_sched #(.ADD_LAT(3), .MUL_LAT(4)) dut (
        .clk(clk), .rst(rst), .bus(bus), .flush(flush),
        .fp_a(fp_a), .fp_b(fp_b), .fp_add_ans(fp_add_ans), .fp_mul_ans(fp_mul_ans),
        .stall_dx(stall_dx), .busy(busy), .illegal(illegal), .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks until res_valid; returns the number of edges waited, 99 on timeout.
    task automatic wait_valid(output int n);
        n = 0;
        while (bus.res_valid !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        if (bus.res_valid !== 1'b1) n = 99;
    endtask

    task automatic set_op(input logic [3:0] c, input logic [4:0] r, input logic [31:0] a, input logic [31:0] b);
        bus.issue_valid = 1;
        bus.issue_ctrl = c;
        bus.issue_rd = r;
        bus.issue_a = a;
        bus.issue_b = b;
    endtask

    task automatic test_reset();
        bus.issue_valid = 0;
        bus.issue_ctrl = 0;
        bus.issue_rd = 0;
        bus.issue_a = 0;
        bus.issue_b = 0;
        bus.res_ready = 0;
        flush = 0;
        rst = 1;
        tick();
        tick();
        rst = 0;
        #1;
        checks++;
        if ({bus.res_valid, busy, illegal, stall_dx, bus.issue_ready} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_flags got v=%b busy=%b ill=%b stall=%b rdy=%b want 00001",
                     bus.res_valid, busy, illegal, stall_dx, bus.issue_ready);
        end
        checks++;
        if ({fp_a, fp_b, bus.res_data, bus.res_rd, ops_done} !== '0) begin
            errors++;
            $display("FAIL reset_data got a=%h b=%h d=%h rd=%0d ops=%0d want all 0",
                     fp_a, fp_b, bus.res_data, bus.res_rd, ops_done);
        end
    endtask

    task automatic test_add();
        int n;
        fp_add_ans = 32'h40400000;
        fp_mul_ans = 32'hDEADBEEF;
        bus.res_ready = 1;
        set_op(4'd9, 5'd3, 32'h3F800000, 32'h40000000);
        #1;
        checks++;
        if (bus.issue_ready !== 1'b1 || stall_dx !== 1'b0) begin
            errors++;
            $display("FAIL add_ready got rdy=%b stall=%b want 1 0", bus.issue_ready, stall_dx);
        end
        tick();
        bus.issue_valid = 0;
        checks++;
        if (busy !== 1'b1 || fp_a !== 32'h3F800000 || fp_b !== 32'h40000000) begin
            errors++;
            $display("FAIL add_issue got busy=%b a=%h b=%h want 1 3f800000 40000000", busy, fp_a, fp_b);
        end
        wait_valid(n);
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL add_latency got %0d want 3", n);
        end
        checks++;
        if (bus.res_data !== 32'h40400000 || bus.res_rd !== 5'd3) begin
            errors++;
            $display("FAIL add_result got %h rd=%0d want 40400000 rd=3", bus.res_data, bus.res_rd);
        end
        tick();
        checks++;
        if (ops_done !== 16'd1 || bus.res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL add_consume got ops=%0d v=%b busy=%b want 1 0 0", ops_done, bus.res_valid, busy);
        end
    endtask

    task automatic test_backpressure();
        int n;
        bit stable = 1;
        bus.res_ready = 0;
        fp_mul_ans = 32'h40C00000;
        fp_add_ans = 32'h12345678;
        set_op(4'd10, 5'd7, 32'h40000000, 32'h40400000);
        tick();
        bus.issue_valid = 0;
        wait_valid(n);
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL mul_latency got %0d want 4", n);
        end
        set_op(4'd9, 5'd9, 32'h00000001, 32'h00000002);
        fp_mul_ans = 32'h0;
        #1;
        checks++;
        if (stall_dx !== 1'b1 || bus.issue_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall got stall=%b rdy=%b want 1 0", stall_dx, bus.issue_ready);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.res_valid !== 1'b1 || bus.res_data !== 32'h40C00000 || bus.res_rd !== 5'd7) stable = 0;
        end
        checks++;
        if (!stable) begin
            errors++;
            $display("FAIL bp_hold got v=%b d=%h rd=%0d want 1 40c00000 7", bus.res_valid, bus.res_data, bus.res_rd);
        end
        bus.res_ready = 1;
        #1;
        checks++;
        if (bus.issue_ready !== 1'b1 || stall_dx !== 1'b0) begin
            errors++;
            $display("FAIL bp_release got rdy=%b stall=%b want 1 0", bus.issue_ready, stall_dx);
        end
        tick();
        bus.issue_valid = 0;
        checks++;
        if (busy !== 1'b1 || bus.res_valid !== 1'b0 || ops_done !== 16'd2 || fp_a !== 32'h1) begin
            errors++;
            $display("FAIL bp_b2b got busy=%b v=%b ops=%0d a=%h want 1 0 2 00000001", busy, bus.res_valid, ops_done, fp_a);
        end
        wait_valid(n);
        checks++;
        if (n != 3 || bus.res_data !== 32'h12345678 || bus.res_rd !== 5'd9) begin
            errors++;
            $display("FAIL bp_second got n=%0d d=%h rd=%0d want 3 12345678 9", n, bus.res_data, bus.res_rd);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int t[4];
        logic [31:0] d[4];
        logic [4:0] r[4];
        int k = 0, nr = 0, cyc = -1;
        logic acc;
        int exp_t[4] = '{3, 8, 12, 17};
        test_reset();
        fp_add_ans = 32'h11111111;
        fp_mul_ans = 32'h22222222;
        bus.res_ready = 1;
        set_op(4'd9, 5'd1, 32'h0, 32'h0);
        for (int i = 0; i < 40 && nr < 4; i++) begin
            #1;
            acc = bus.issue_valid && bus.issue_ready;
            tick();
            cyc++;
            if (acc) begin
                k++;
                if (k < 4) set_op(k[0] ? 4'd10 : 4'd9, 5'(k + 1), 32'h0, 32'h0);
                else bus.issue_valid = 0;
            end
            if (bus.res_valid === 1'b1) begin
                t[nr] = cyc;
                d[nr] = bus.res_data;
                r[nr] = bus.res_rd;
                nr++;
            end
        end
        checks++;
        if (nr != 4) begin
            errors++;
            $display("FAIL b2b_count got %0d results want 4", nr);
        end
        for (int i = 0; i < nr; i++) begin
            checks++;
            if (t[i] != exp_t[i] || d[i] !== (i[0] ? 32'h22222222 : 32'h11111111) || r[i] !== 5'(i + 1)) begin
                errors++;
                $display("FAIL b2b_res%0d got t=%0d d=%h rd=%0d want t=%0d d=%h rd=%0d",
                         i, t[i], d[i], r[i], exp_t[i], i[0] ? 32'h22222222 : 32'h11111111, i + 1);
            end
        end
        tick();
        checks++;
        if (ops_done !== 16'd4 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ops got ops=%0d busy=%b want 4 0", ops_done, busy);
        end
    endtask

    task automatic test_flush();
        int n;
        bit seen = 0;
        bus.res_ready = 0;
        set_op(4'd10, 5'd5, 32'h5, 32'h6);
        tick();
        bus.issue_valid = 0;
        tick();
        flush = 1;
        tick();
        flush = 0;
        checks++;
        if (busy !== 1'b0 || bus.res_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_busy got busy=%b v=%b want 0 0", busy, bus.res_valid);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.res_valid !== 1'b0) seen = 1;
        end
        checks++;
        if (seen || ops_done !== 16'd4) begin
            errors++;
            $display("FAIL flush_busy_after got seen=%b ops=%0d want 0 4", seen, ops_done);
        end
        set_op(4'd9, 5'd6, 32'h7, 32'h8);
        tick();
        bus.issue_valid = 0;
        wait_valid(n);
        bus.res_ready = 1;
        flush = 1;
        tick();
        flush = 0;
        bus.res_ready = 0;
        checks++;
        if (n != 3 || busy !== 1'b0 || bus.res_valid !== 1'b0 || ops_done !== 16'd4) begin
            errors++;
            $display("FAIL flush_done got n=%0d busy=%b v=%b ops=%0d want 3 0 0 4", n, busy, bus.res_valid, ops_done);
        end
        set_op(4'd9, 5'd2, 32'hAA, 32'hBB);
        flush = 1;
        #1;
        checks++;
        if (bus.issue_ready !== 1'b0 || stall_dx !== 1'b1) begin
            errors++;
            $display("FAIL flush_issue_rdy got rdy=%b stall=%b want 0 1", bus.issue_ready, stall_dx);
        end
        tick();
        flush = 0;
        bus.issue_valid = 0;
        checks++;
        if (busy !== 1'b0 || fp_a === 32'hAA) begin
            errors++;
            $display("FAIL flush_issue got busy=%b a=%h want 0 not aa", busy, fp_a);
        end
    endtask

    task automatic test_illegal();
        set_op(4'd2, 5'd1, 32'h1, 32'h1);
        #1;
        checks++;
        if (stall_dx !== 1'b0 || bus.issue_ready !== 1'b1) begin
            errors++;
            $display("FAIL ill_comb got stall=%b rdy=%b want 0 1", stall_dx, bus.issue_ready);
        end
        tick();
        bus.issue_valid = 0;
        checks++;
        if (illegal !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ill_pulse got ill=%b busy=%b want 1 0", illegal, busy);
        end
        tick();
        checks++;
        if (illegal !== 1'b0) begin
            errors++;
            $display("FAIL ill_clear got %b want 0", illegal);
        end
    endtask

    task automatic test_rst_busy();
        bit seen = 0;
        bus.res_ready = 1;
        set_op(4'd9, 5'd4, 32'hCAFE, 32'hBEEF);
        tick();
        bus.issue_valid = 0;
        tick();
        rst = 1;
        tick();
        rst = 0;
        checks++;
        if ({busy, bus.res_valid, illegal} !== 3'b000 || {fp_a, fp_b, bus.res_data, bus.res_rd, ops_done} !== '0) begin
            errors++;
            $display("FAIL rst_busy got busy=%b v=%b a=%h b=%h d=%h ops=%0d want all 0",
                     busy, bus.res_valid, fp_a, fp_b, bus.res_data, ops_done);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.res_valid !== 1'b0) seen = 1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL rst_no_result got res_valid seen want never");
        end
    endtask

    task automatic test_wrap();
        int n;
        force dut.ops_done = 16'hFFFF;
        tick();
        release dut.ops_done;
        tick();
        checks++;
        if (ops_done !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_preload got %h want ffff", ops_done);
        end
        bus.res_ready = 1;
        set_op(4'd9, 5'd1, 32'h1, 32'h1);
        tick();
        bus.issue_valid = 0;
        wait_valid(n);
        tick();
        checks++;
        if (n != 3 || ops_done !== 16'h0000) begin
            errors++;
            $display("FAIL wrap got n=%0d ops=%h want 3 0000", n, ops_done);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_illegal();
        test_rst_busy();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
